// File: rtl/ivs_ahb_regbank.sv
// IVS configuration register bank on AHB-Lite.
// Control, NUM_PAR parameters, trigger/status, lock and timed soft reset.
module ivs_ahb_regbank #(
    parameter int NUM_PAR   = 16,
    parameter int ADDR_W    = 12,
    parameter int PAR_BASE  = 'h100,
    parameter int RST_PULSE = 4
) (
    input  logic                   hclk,
    input  logic                   hrst_n,
    input  logic                   hsel,
    input  logic [1:0]             htrans,
    input  logic                   hwrite,
    input  logic [31:0]            haddr,
    input  logic [2:0]             hsize,
    input  logic [31:0]            hwdata,
    input  logic                   hready_in,
    output logic                   hready_out,
    output logic [1:0]             hresp,
    output logic [31:0]            hrdata,
    output logic [31:0]            glb_ctrl,
    output logic [NUM_PAR*32-1:0]  cfg_par,
    output logic [NUM_PAR-1:0]     cfg_wr_pulse,
    output logic                   lock,
    output logic                   sw_rst
);

    localparam int          IDX_W     = (NUM_PAR > 1) ? $clog2(NUM_PAR) : 1;
    localparam logic [31:0] PAR_WBASE = 32'(PAR_BASE) >> 2;
    localparam logic [31:0] PAR_WEND  = PAR_WBASE + 32'(NUM_PAR);
    localparam logic [7:0]  PULSE_LD  = 8'(RST_PULSE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ERR1 = 2'd1,
        S_ERR2 = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [31:0]      r_glb;
    logic [31:0]      r_par [NUM_PAR];
    logic [NUM_PAR-1:0] r_wr_pulse;
    logic             r_lock;
    logic [7:0]       r_err_cnt;
    logic [7:0]       r_rst_cnt;
    logic             r_sw_rst;

    logic             r_dp_ok;
    logic             r_dp_wr;
    logic             r_dp_glb;
    logic             r_dp_trig;
    logic             r_dp_stat;
    logic             r_dp_par;
    logic [IDX_W-1:0] r_dp_pidx;
    logic [1:0]       r_dp_size;
    logic [1:0]       r_dp_lo;

    logic [31:0]      w_waddr;
    logic [31:0]      w_par_rel;
    logic             w_a_glb;
    logic             w_a_trig;
    logic             w_a_stat;
    logic             w_a_par;
    logic             w_a_bad_size;
    logic             w_a_misal;
    logic             w_a_wrprot;
    logic             w_a_err;
    logic             w_accept;
    logic             w_lock_eff;

    logic [3:0]       w_be;
    logic [31:0]      w_mask;
    logic             w_wr;
    logic             w_trig_wr;
    logic             w_lock_set;
    logic             w_pulse_ld;
    logic [7:0]       w_cnt_nxt;
    logic [31:0]      w_par_rd;
    logic [31:0]      w_status;

    // Address-phase decode; the error verdict is known before the data phase.
    assign w_waddr    = 32'(haddr[ADDR_W-1:2]);
    assign w_par_rel  = w_waddr - PAR_WBASE;
    assign w_a_glb    = (w_waddr == 32'd0);
    assign w_a_trig   = (w_waddr == 32'd1);
    assign w_a_stat   = (w_waddr == 32'd2);
    assign w_a_par    = (w_waddr >= PAR_WBASE) && (w_waddr < PAR_WEND);

    assign w_a_bad_size = hsize[2] | (hsize[1] & hsize[0]);
    assign w_a_misal    = ((hsize == 3'd2) & (|haddr[1:0]))
                        | ((hsize == 3'd1) & haddr[0]);

    // A lock set by the TRIG write now in its data phase already applies.
    assign w_lock_eff = r_lock | w_lock_set;
    assign w_a_wrprot = hwrite & (w_a_stat
                      | (w_lock_eff & (w_a_glb | w_a_par)));

    assign w_a_err = ~(w_a_glb | w_a_trig | w_a_stat | w_a_par)
                   | w_a_bad_size | w_a_misal | w_a_wrprot;

    assign w_accept = hsel & htrans[1] & hready_in & hready_out;

    always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) begin
            r_dp_ok   <= 1'b0;
            r_dp_wr   <= 1'b0;
            r_dp_glb  <= 1'b0;
            r_dp_trig <= 1'b0;
            r_dp_stat <= 1'b0;
            r_dp_par  <= 1'b0;
            r_dp_pidx <= '0;
            r_dp_size <= 2'd0;
            r_dp_lo   <= 2'd0;
        end else begin
            r_dp_ok <= w_accept & ~w_a_err;
            if (w_accept) begin
                r_dp_wr   <= hwrite;
                r_dp_glb  <= w_a_glb;
                r_dp_trig <= w_a_trig;
                r_dp_stat <= w_a_stat;
                r_dp_par  <= w_a_par;
                r_dp_pidx <= w_par_rel[IDX_W-1:0];
                r_dp_size <= hsize[1:0];
                r_dp_lo   <= haddr[1:0];
            end
        end
    end

    always_comb begin
        w_be = 4'b0000;
        case (r_dp_size)
            2'd0:    w_be = 4'b0001 << r_dp_lo;
            2'd1:    w_be = r_dp_lo[1] ? 4'b1100 : 4'b0011;
            2'd2:    w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    assign w_mask = {{8{w_be[3]}}, {8{w_be[2]}},
                     {8{w_be[1]}}, {8{w_be[0]}}};

    assign w_wr       = r_dp_ok & r_dp_wr;
    assign w_trig_wr  = w_wr & r_dp_trig & w_be[0];
    assign w_lock_set = w_trig_wr & hwdata[1];
    assign w_pulse_ld = w_trig_wr & hwdata[0];

    always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) begin
            r_glb <= 32'd0;
        end else if (w_wr & r_dp_glb) begin
            r_glb <= (r_glb & ~w_mask) | (hwdata & w_mask);
        end
    end

    always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) begin
            for (int i = 0; i < NUM_PAR; i++) begin
                r_par[i] <= 32'd0;
            end
            r_wr_pulse <= '0;
        end else begin
            for (int i = 0; i < NUM_PAR; i++) begin
                r_wr_pulse[i] <= 1'b0;
                if (w_wr & r_dp_par & (r_dp_pidx == IDX_W'(i))) begin
                    r_par[i]      <= (r_par[i] & ~w_mask) | (hwdata & w_mask);
                    r_wr_pulse[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) begin
            r_lock <= 1'b0;
        end else if (w_lock_set) begin
            r_lock <= 1'b1;
        end
    end

    always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) begin
            r_err_cnt <= 8'd0;
        end else if (w_accept & w_a_err & (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    // Retrigger reloads the counter, so the pulse stretches.
    always_comb begin
        w_cnt_nxt = r_rst_cnt;
        if (w_pulse_ld) begin
            w_cnt_nxt = PULSE_LD;
        end else if (r_rst_cnt != 8'd0) begin
            w_cnt_nxt = r_rst_cnt - 8'd1;
        end
    end

    always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) begin
            r_rst_cnt <= 8'd0;
            r_sw_rst  <= 1'b0;
        end else begin
            r_rst_cnt <= w_cnt_nxt;
            r_sw_rst  <= (w_cnt_nxt != 8'd0);
        end
    end

    always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  w_state_nxt = (w_accept & w_a_err) ? S_ERR1 : S_IDLE;
            S_ERR1:  w_state_nxt = S_ERR2;
            S_ERR2:  w_state_nxt = (w_accept & w_a_err) ? S_ERR1 : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        hready_out = 1'b1;
        hresp      = 2'b00;
        unique case (r_state)
            S_ERR1: begin
                hready_out = 1'b0;
                hresp      = 2'b01;
            end
            S_ERR2:  hresp = 2'b01;
            default: hresp = 2'b00;
        endcase
    end

    always_comb begin
        w_par_rd = 32'd0;
        for (int i = 0; i < NUM_PAR; i++) begin
            if (r_dp_pidx == IDX_W'(i)) begin
                w_par_rd = r_par[i];
            end
        end
    end

    assign w_status = {16'd0, r_err_cnt, 6'd0, r_sw_rst, r_lock};

    always_comb begin
        hrdata = 32'd0;
        if (r_dp_ok & ~r_dp_wr) begin
            unique case (1'b1)
                r_dp_glb:  hrdata = r_glb;
                r_dp_stat: hrdata = w_status;
                r_dp_par:  hrdata = w_par_rd;
                default:   hrdata = 32'd0;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_PAR; g++) begin : g_par
        assign cfg_par[32*g +: 32] = r_par[g];
    end

    assign glb_ctrl     = r_glb;
    assign cfg_wr_pulse = r_wr_pulse;
    assign lock         = r_lock;
    assign sw_rst       = r_sw_rst;

    logic w_unused;
    assign w_unused = ^{htrans[0], haddr[31:ADDR_W], w_par_rel[31:IDX_W]};

endmodule

// File: tb/tb_ivs_ahb_regbank.sv
// Directed bench for ivs_ahb_regbank (default parameters).
// Each task drives one scenario and checks its own results.
module tb_ivs_ahb_regbank;

    logic         hclk = 1'b0;
    logic         hrst_n = 1'b0;
    logic         hsel = 1'b0;
    logic [1:0]   htrans = 2'b00;
    logic         hwrite = 1'b0;
    logic [31:0]  haddr = 32'd0;
    logic [2:0]   hsize = 3'd2;
    logic [31:0]  hwdata = 32'd0;
    logic         hready_in;
    logic         hready_out;
    logic [1:0]   hresp;
    logic [31:0]  hrdata;
    logic [31:0]  glb_ctrl;
    logic [511:0] cfg_par;
    logic [15:0]  cfg_wr_pulse;
    logic         lock;
    logic         sw_rst;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [5:0] TR_OK  = 6'b100_000;
    localparam logic [5:0] TR_ERR = 6'b001_101;

    assign hready_in = hready_out;

    ivs_ahb_regbank dut (
        .hclk         (hclk),
        .hrst_n       (hrst_n),
        .hsel         (hsel),
        .htrans       (htrans),
        .hwrite       (hwrite),
        .haddr        (haddr),
        .hsize        (hsize),
        .hwdata       (hwdata),
        .hready_in    (hready_in),
        .hready_out   (hready_out),
        .hresp        (hresp),
        .hrdata       (hrdata),
        .glb_ctrl     (glb_ctrl),
        .cfg_par      (cfg_par),
        .cfg_wr_pulse (cfg_wr_pulse),
        .lock         (lock),
        .sw_rst       (sw_rst)
    );

    always #5 hclk = ~hclk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge hclk);
        #1;
    endtask

    task automatic bus_idle();
        hsel   = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
    endtask

    // One isolated transfer; trace = {rdy,resp} of data cycle 1 and,
    // if stretched, of the cycle where hready_out returns.
    task automatic xfer(input logic wr, input logic [31:0] addr,
                        input logic [2:0] sz, input logic [31:0] wd,
                        output logic [31:0] rd, output logic [5:0] tr);
        int n;
        hsel   = 1'b1;
        htrans = 2'b10;
        hwrite = wr;
        haddr  = addr;
        hsize  = sz;
        cyc();
        bus_idle();
        hwdata = wd;
        rd = hrdata;
        tr = {hready_out, hresp, 3'b000};
        if (!hready_out) begin
            n = 0;
            while (!hready_out && n < 4) begin
                cyc();
                n++;
            end
            tr[2:0] = {hready_out, hresp};
        end
        cyc();
    endtask

    // Write immediately followed by a read; returns read data.
    task automatic b2b(input logic [31:0] waddr, input logic [2:0] wsz,
                       input logic [31:0] wd, input logic [31:0] raddr,
                       output logic [31:0] rd, output logic rdy);
        hsel   = 1'b1;
        htrans = 2'b10;
        hwrite = 1'b1;
        haddr  = waddr;
        hsize  = wsz;
        cyc();
        hwdata = wd;
        hwrite = 1'b0;
        haddr  = raddr;
        hsize  = 3'd2;
        rdy    = hready_out;
        cyc();
        bus_idle();
        rd = hrdata;
        cyc();
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [5:0]  tr;
        logic [31:0] addrs [3];
        hrst_n = 1'b0;
        repeat (3) cyc();
        n_cmp++;
        if ({hready_out, hresp} !== 3'b100) begin
            n_bad++;
            $display("FAIL rst_resp: got %b want 100", {hready_out, hresp});
        end
        n_cmp++;
        if (glb_ctrl !== 32'd0 || cfg_par !== 512'd0) begin
            n_bad++;
            $display("FAIL rst_regs: got glb %h par_nonzero %b want 0",
                     glb_ctrl, |cfg_par);
        end
        n_cmp++;
        if ({cfg_wr_pulse, lock, sw_rst, hrdata} !== 50'd0) begin
            n_bad++;
            $display("FAIL rst_outs: got pulse %h lock %b swr %b rd %h want 0",
                     cfg_wr_pulse, lock, sw_rst, hrdata);
        end
        #2;
        hrst_n = 1'b1;
        cyc();
        addrs[0] = 32'h000;
        addrs[1] = 32'h008;
        addrs[2] = 32'h100;
        for (int i = 0; i < 3; i++) begin
            xfer(1'b0, addrs[i], 3'd2, 32'd0, rd, tr);
            n_cmp++;
            if (rd !== 32'd0 || tr !== TR_OK) begin
                n_bad++;
                $display("FAIL rst_read %h: got %h/%b want 0/%b",
                         addrs[i], rd, tr, TR_OK);
            end
        end
    endtask

    task automatic test_word_write();
        logic [31:0] rd;
        logic [5:0]  tr;
        xfer(1'b1, 32'h108, 3'd2, 32'hDEADBEEF, rd, tr);
        n_cmp++;
        if (tr !== TR_OK) begin
            n_bad++;
            $display("FAIL ww_resp: got %b want %b", tr, TR_OK);
        end
        n_cmp++;
        if (cfg_wr_pulse !== 16'h0004 || cfg_par[95:64] !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL ww_pulse: got %h par2 %h want 0004 deadbeef",
                     cfg_wr_pulse, cfg_par[95:64]);
        end
        cyc();
        n_cmp++;
        if (cfg_wr_pulse !== 16'h0000) begin
            n_bad++;
            $display("FAIL ww_pulse_end: got %h want 0000", cfg_wr_pulse);
        end
        xfer(1'b0, 32'h108, 3'd2, 32'd0, rd, tr);
        n_cmp++;
        if (rd !== 32'hDEADBEEF || tr !== TR_OK) begin
            n_bad++;
            $display("FAIL ww_read: got %h/%b want deadbeef/%b", rd, tr, TR_OK);
        end
    endtask

    task automatic test_byte_write();
        logic [31:0] rd;
        logic [5:0]  tr;
        xfer(1'b1, 32'h100, 3'd2, 32'h11223344, rd, tr);
        xfer(1'b1, 32'h101, 3'd0, 32'h00005A00, rd, tr);
        n_cmp++;
        if (tr !== TR_OK || cfg_wr_pulse !== 16'h0001) begin
            n_bad++;
            $display("FAIL bw_resp: got %b pulse %h want %b 0001",
                     tr, cfg_wr_pulse, TR_OK);
        end
        xfer(1'b0, 32'h100, 3'd2, 32'd0, rd, tr);
        n_cmp++;
        if (rd !== 32'h11225A44) begin
            n_bad++;
            $display("FAIL bw_read: got %h want 11225a44", rd);
        end
        xfer(1'b1, 32'h101, 3'd1, 32'hFFFFFFFF, rd, tr);
        n_cmp++;
        if (tr !== TR_ERR) begin
            n_bad++;
            $display("FAIL hw_misal_resp: got %b want %b", tr, TR_ERR);
        end
        xfer(1'b0, 32'h100, 3'd2, 32'd0, rd, tr);
        n_cmp++;
        if (rd !== 32'h11225A44) begin
            n_bad++;
            $display("FAIL hw_misal_keep: got %h want 11225a44", rd);
        end
        xfer(1'b0, 32'h008, 3'd2, 32'd0, rd, tr);
        n_cmp++;
        if (rd !== 32'h00000100) begin
            n_bad++;
            $display("FAIL status_err1: got %h want 00000100", rd);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] rd;
        logic [5:0]  tr;
        xfer(1'b0, 32'h0FC, 3'd2, 32'd0, rd, tr);
        n_cmp++;
        if (tr !== TR_ERR || rd !== 32'd0) begin
            n_bad++;
            $display("FAIL unmapped: got %b/%h want %b/0", tr, rd, TR_ERR);
        end
        xfer(1'b0, 32'h008, 3'd2, 32'd0, rd, tr);
        n_cmp++;
        if (rd !== 32'h00000200) begin
            n_bad++;
            $display("FAIL status_err2: got %h want 00000200", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic        rdy;
        b2b(32'h000, 3'd2, 32'hA5A50001, 32'h000, rd, rdy);
        n_cmp++;
        if (rd !== 32'hA5A50001 || rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_glb: got %h rdy %b want a5a50001 1", rd, rdy);
        end
        b2b(32'h102, 3'd1, 32'hCAFE0000, 32'h100, rd, rdy);
        n_cmp++;
        if (rd !== 32'hCAFE5A44) begin
            n_bad++;
            $display("FAIL b2b_half: got %h want cafe5a44", rd);
        end
    endtask

    task automatic test_lock();
        logic [31:0] rd;
        logic [5:0]  tr;
        int          n;
        xfer(1'b1, 32'h004, 3'd2, 32'h00000002, rd, tr);
        n_cmp++;
        if (tr !== TR_OK || lock !== 1'b1) begin
            n_bad++;
            $display("FAIL lock_set: got %b lock %b want %b 1", tr, lock, TR_OK);
        end
        xfer(1'b1, 32'h000, 3'd2, 32'h12345678, rd, tr);
        n_cmp++;
        if (tr !== TR_ERR || glb_ctrl !== 32'hA5A50001) begin
            n_bad++;
            $display("FAIL lock_glb: got %b glb %h want %b a5a50001",
                     tr, glb_ctrl, TR_ERR);
        end
        xfer(1'b0, 32'h008, 3'd2, 32'd0, rd, tr);
        n_cmp++;
        if (rd !== 32'h00000301) begin
            n_bad++;
            $display("FAIL lock_status: got %h want 00000301", rd);
        end
        xfer(1'b1, 32'h104, 3'd2, 32'h0000FFFF, rd, tr);
        n_cmp++;
        if (tr !== TR_ERR || cfg_par[63:32] !== 32'd0) begin
            n_bad++;
            $display("FAIL lock_par: got %b par1 %h want %b 0",
                     tr, cfg_par[63:32], TR_ERR);
        end
        xfer(1'b0, 32'h100, 3'd2, 32'd0, rd, tr);
        n_cmp++;
        if (rd !== 32'hCAFE5A44 || tr !== TR_OK) begin
            n_bad++;
            $display("FAIL lock_read: got %h/%b want cafe5a44/%b", rd, tr, TR_OK);
        end
        xfer(1'b1, 32'h004, 3'd2, 32'h00000001, rd, tr);
        n_cmp++;
        if (tr !== TR_OK) begin
            n_bad++;
            $display("FAIL lock_trig: got %b want %b", tr, TR_OK);
        end
        xfer(1'b0, 32'h008, 3'd2, 32'd0, rd, tr);
        n_cmp++;
        if (rd !== 32'h00000403) begin
            n_bad++;
            $display("FAIL lock_status2: got %h want 00000403", rd);
        end
        n = 0;
        while (sw_rst && n < 20) begin
            cyc();
            n++;
        end
        n_cmp++;
        if (sw_rst !== 1'b0) begin
            n_bad++;
            $display("FAIL swr_drain: got %b want 0", sw_rst);
        end
    endtask

    task automatic test_sw_rst();
        logic [9:0]  seen;
        logic [31:0] rd;
        logic [5:0]  tr;
        for (int k = 0; k < 10; k++) begin
            seen[k] = sw_rst;
            bus_idle();
            if (k == 0 || k == 2) begin
                hsel   = 1'b1;
                htrans = 2'b10;
                hwrite = 1'b1;
                haddr  = 32'h004;
                hsize  = 3'd2;
            end
            if (k == 1 || k == 3) hwdata = 32'h00000001;
            cyc();
        end
        n_cmp++;
        if (seen !== 10'b00_1111_1100) begin
            n_bad++;
            $display("FAIL swr_pulse: got %b want 0011111100", seen);
        end
        xfer(1'b1, 32'h004, 3'd2, 32'h00000001, rd, tr);
        cyc();
        n_cmp++;
        if (sw_rst !== 1'b1) begin
            n_bad++;
            $display("FAIL swr_mid: got %b want 1", sw_rst);
        end
        #2;
        hrst_n = 1'b0;
        #1;
        n_cmp++;
        if ({sw_rst, lock, hready_out} !== 3'b001) begin
            n_bad++;
            $display("FAIL swr_async_rst: got %b want 001",
                     {sw_rst, lock, hready_out});
        end
        cyc();
        #2;
        hrst_n = 1'b1;
        cyc();
        xfer(1'b0, 32'h008, 3'd2, 32'd0, rd, tr);
        n_cmp++;
        if (rd !== 32'd0 || tr !== TR_OK) begin
            n_bad++;
            $display("FAIL swr_status: got %h/%b want 0/%b", rd, tr, TR_OK);
        end
    endtask

    initial begin
        test_reset();
        test_word_write();
        test_byte_write();
        test_unmapped();
        test_back_to_back();
        test_lock();
        test_sw_rst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
